// File: rtl/cu_pkg.sv
// Shared types and constants for the multi-cycle control unit.
package cu_pkg;

    // Base 3-bit instruction set; wider opcodes above 7 are undefined.
    typedef enum logic [2:0] {
        OpSet   = 3'd0,
        OpLdpx  = 3'd1,
        OpModex = 3'd2,
        OpStpx  = 3'd3,
        OpCmpeq = 3'd4,
        OpJeq   = 3'd5,
        OpJ     = 3'd6,
        OpAdd   = 3'd7
    } opcode_e;

    localparam logic [1:0] AluAdd  = 2'b00;
    localparam logic [1:0] AluCmp  = 2'b01;
    localparam logic [1:0] AluMod  = 2'b10;
    localparam logic [1:0] AluPass = 2'b11;

    // Field order matches the documented opcode map, MSB first.
    typedef struct packed {
        logic       rd_register_en;
        logic       wb_enable;
        logic       rd_mem_en;
        logic       wr_mem_en;
        logic       mux_id;
        logic       mux_exe;
        logic       mux_mem;
        logic       jenable;
        logic [1:0] alu_op;
    } ctrl_t;

    localparam ctrl_t NopCtrl = '{
        rd_register_en: 1'b0, wb_enable: 1'b0, rd_mem_en: 1'b0, wr_mem_en: 1'b0,
        mux_id: 1'b0, mux_exe: 1'b0, mux_mem: 1'b0, jenable: 1'b0, alu_op: AluPass
    };

    typedef enum logic [1:0] {
        StRun    = 2'd0,
        StMcWait = 2'd1,
        StFlush  = 2'd2
    } state_e;

endpackage

// File: rtl/control_unit_mc_if.sv
// Pipeline-facing signals of the control unit; slave is the control unit itself.
interface control_unit_mc_if #(
    parameter int unsigned OPCODE_W = 3
);
    logic [OPCODE_W-1:0] opcode;
    logic                instr_valid;
    logic                alu_done;
    logic                jump_taken;

    logic                rd_register_en;
    logic                wb_enable;
    logic                rd_mem_en;
    logic                wr_mem_en;
    logic                mux_id;
    logic                mux_exe;
    logic                mux_mem;
    logic                jenable;
    logic [1:0]          alu_op;
    logic                alu_start;
    logic                pc_en;
    logic                stall;
    logic                flush;
    logic                illegal;
    logic                timeout;

    modport master (
        output opcode, instr_valid, alu_done, jump_taken,
        input  rd_register_en, wb_enable, rd_mem_en, wr_mem_en, mux_id, mux_exe, mux_mem,
        input  jenable, alu_op, alu_start, pc_en, stall, flush, illegal, timeout
    );

    modport slave (
        input  opcode, instr_valid, alu_done, jump_taken,
        output rd_register_en, wb_enable, rd_mem_en, wr_mem_en, mux_id, mux_exe, mux_mem,
        output jenable, alu_op, alu_start, pc_en, stall, flush, illegal, timeout
    );
endinterface

// File: rtl/cu_decode.sv
// Pure combinational opcode-to-control-bundle map.
module cu_decode
    import cu_pkg::*;
#(
    parameter int unsigned OPCODE_W = 3
) (
    input  logic [OPCODE_W-1:0] opcode_i,
    output ctrl_t               ctrl_o,
    output logic                illegal_o,
    output logic                modex_o
);

    logic [31:0] op_ext;

    assign op_ext = 32'(opcode_i);

    // Map the low three bits; anything above 7 becomes a flagged NOP.
    always_comb begin
        ctrl_o    = NopCtrl;
        illegal_o = 1'b0;
        modex_o   = 1'b0;
        if (op_ext > 32'd7) begin
            illegal_o = 1'b1;
        end else begin
            unique case (opcode_e'(op_ext[2:0]))
                OpSet:       ctrl_o = ctrl_t'(10'b0100_0100_11);
                OpLdpx:      ctrl_o = ctrl_t'(10'b1110_1100_11);
                OpModex: begin
                    ctrl_o  = ctrl_t'(10'b1100_1000_10);
                    modex_o = 1'b1;
                end
                OpStpx:      ctrl_o = ctrl_t'(10'b1001_0110_11);
                OpCmpeq:     ctrl_o = ctrl_t'(10'b1000_0100_01);
                OpJeq, OpJ:  ctrl_o = ctrl_t'(10'b0000_1101_11);
                OpAdd:       ctrl_o = ctrl_t'(10'b1100_1100_00);
                default:     ctrl_o = NopCtrl;
            endcase
        end
    end

endmodule

// File: rtl/control_unit_mc.sv
// Multi-cycle control unit: registered decode plus RUN / MC_WAIT / FLUSH sequencing.
module control_unit_mc
    import cu_pkg::*;
#(
    parameter int unsigned ARQ          = 16,
    parameter int unsigned OPCODE_W     = 3,
    parameter int unsigned MC_TIMEOUT   = 64,
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input logic              clk,
    input logic              rst,
    control_unit_mc_if.slave bus
);

    localparam int unsigned CntW      = $clog2(MC_TIMEOUT + 1);
    localparam logic [2:0]  FlushLoad = 3'(FLUSH_CYCLES - 1);

    if (ARQ < 1) begin : g_bad_arq
        $error("ARQ must be at least 1");
    end
    if (OPCODE_W < 3) begin : g_bad_opw
        $error("OPCODE_W must be at least 3");
    end
    if (FLUSH_CYCLES < 1 || FLUSH_CYCLES > 7) begin : g_bad_flush
        $error("FLUSH_CYCLES must be within 1..7");
    end

    state_e          state_q, state_d;
    logic [CntW-1:0] mc_cnt_q, mc_cnt_d;
    logic [2:0]      fl_cnt_q, fl_cnt_d;

    ctrl_t ctrl_q, ctrl_d;
    logic  alu_start_q, alu_start_d;
    logic  pc_en_q, pc_en_d;
    logic  stall_q, stall_d;
    logic  flush_q, flush_d;
    logic  illegal_q, illegal_d;
    logic  timeout_q, timeout_d;

    ctrl_t dec_ctrl;
    logic  dec_illegal;
    logic  dec_modex;

    cu_decode #(
        .OPCODE_W (OPCODE_W)
    ) u_decode (
        .opcode_i  (bus.opcode),
        .ctrl_o    (dec_ctrl),
        .illegal_o (dec_illegal),
        .modex_o   (dec_modex)
    );

    // Next-state and next-output logic; every output is registered one cycle later.
    always_comb begin
        state_d     = state_q;
        mc_cnt_d    = mc_cnt_q;
        fl_cnt_d    = fl_cnt_q;
        ctrl_d      = NopCtrl;
        alu_start_d = 1'b0;
        pc_en_d     = 1'b1;
        stall_d     = 1'b0;
        flush_d     = 1'b0;
        illegal_d   = 1'b0;
        timeout_d   = 1'b0;

        unique case (state_q)
            StRun: begin
                mc_cnt_d = '0;
                // A taken jump squashes whatever sits in ID, including a MODEX.
                if (bus.jump_taken) begin
                    flush_d  = 1'b1;
                    fl_cnt_d = FlushLoad;
                    state_d  = (FLUSH_CYCLES > 1) ? StFlush : StRun;
                end else if (bus.instr_valid) begin
                    ctrl_d    = dec_ctrl;
                    illegal_d = dec_illegal;
                    if (dec_modex) begin
                        // Writeback is withheld until the ALU reports completion.
                        ctrl_d.wb_enable = 1'b0;
                        alu_start_d      = 1'b1;
                        pc_en_d          = 1'b0;
                        state_d          = StMcWait;
                    end
                end
            end

            StMcWait: begin
                ctrl_d = ctrl_q;
                if (bus.alu_done) begin
                    ctrl_d.wb_enable = 1'b1;
                    mc_cnt_d         = '0;
                    state_d          = StRun;
                end else if (mc_cnt_q >= CntW'(MC_TIMEOUT)) begin
                    ctrl_d.wb_enable = 1'b0;
                    timeout_d        = 1'b1;
                    mc_cnt_d         = '0;
                    state_d          = StRun;
                end else begin
                    stall_d  = 1'b1;
                    pc_en_d  = 1'b0;
                    mc_cnt_d = mc_cnt_q + CntW'(1);
                end
            end

            StFlush: begin
                flush_d  = 1'b1;
                fl_cnt_d = (fl_cnt_q == 3'd0) ? 3'd0 : fl_cnt_q - 3'd1;
                if (fl_cnt_q <= 3'd1) begin
                    state_d = StRun;
                end
            end

            default: begin
                state_d = StRun;
            end
        endcase
    end

    // State, counters and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StRun;
            mc_cnt_q    <= '0;
            fl_cnt_q    <= '0;
            ctrl_q      <= NopCtrl;
            alu_start_q <= 1'b0;
            pc_en_q     <= 1'b0;
            stall_q     <= 1'b0;
            flush_q     <= 1'b0;
            illegal_q   <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            mc_cnt_q    <= mc_cnt_d;
            fl_cnt_q    <= fl_cnt_d;
            ctrl_q      <= ctrl_d;
            alu_start_q <= alu_start_d;
            pc_en_q     <= pc_en_d;
            stall_q     <= stall_d;
            flush_q     <= flush_d;
            illegal_q   <= illegal_d;
            timeout_q   <= timeout_d;
        end
    end

    assign bus.rd_register_en = ctrl_q.rd_register_en;
    assign bus.wb_enable      = ctrl_q.wb_enable;
    assign bus.rd_mem_en      = ctrl_q.rd_mem_en;
    assign bus.wr_mem_en      = ctrl_q.wr_mem_en;
    assign bus.mux_id         = ctrl_q.mux_id;
    assign bus.mux_exe        = ctrl_q.mux_exe;
    assign bus.mux_mem        = ctrl_q.mux_mem;
    assign bus.jenable        = ctrl_q.jenable;
    assign bus.alu_op         = ctrl_q.alu_op;
    assign bus.alu_start      = alu_start_q;
    assign bus.pc_en          = pc_en_q;
    assign bus.stall          = stall_q;
    assign bus.flush          = flush_q;
    assign bus.illegal        = illegal_q;
    assign bus.timeout        = timeout_q;

endmodule

// File: tb/tb_control_unit_mc.sv
// Bench for control_unit_mc: directed scenarios then random traffic vs. a cycle model.
module tb_control_unit_mc;

    localparam int OpW     = 4;
    localparam int Timeout = 8;
    localparam int FlushN  = 2;

    // Control bundles straight from the opcode map: rd_reg wb rd_mem wr_mem id exe mem jen alu_op.
    localparam logic [9:0] SpecTbl [8] = '{
        10'b0100_0100_11, 10'b1110_1100_11, 10'b1100_1000_10, 10'b1001_0110_11,
        10'b1000_0100_01, 10'b0000_1101_11, 10'b0000_1101_11, 10'b1100_1100_00
    };
    localparam logic [9:0] NopBundle = 10'b0000_0000_11;

    logic clk;
    logic rst;

    control_unit_mc_if #(.OPCODE_W(OpW)) bus ();

    control_unit_mc #(
        .ARQ          (16),
        .OPCODE_W     (OpW),
        .MC_TIMEOUT   (Timeout),
        .FLUSH_CYCLES (FlushN)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // Model: how many stall cycles an outstanding MODEX has seen (-1: none) and flush bubbles left.
    int         wait_n     = -1;
    int         flush_left = 0;
    logic [9:0] exp_ctrl;
    logic [5:0] exp_flags;  // {alu_start, pc_en, stall, flush, illegal, timeout}

    task automatic model(input logic r, input logic [3:0] op, input logic v, input logic d,
                         input logic j);
        exp_ctrl  = NopBundle;
        exp_flags = 6'b010000;
        if (r) begin
            exp_flags  = 6'b000000;
            wait_n     = -1;
            flush_left = 0;
        end else if (wait_n >= 0) begin
            exp_ctrl    = SpecTbl[2];
            exp_ctrl[8] = 1'b0;
            if (d) begin
                exp_ctrl[8] = 1'b1;
                wait_n      = -1;
            end else if (wait_n >= Timeout) begin
                exp_flags[0] = 1'b1;
                wait_n       = -1;
            end else begin
                exp_flags = 6'b001000;
                wait_n++;
            end
        end else if (flush_left > 0) begin
            exp_flags[2] = 1'b1;
            flush_left--;
        end else if (j) begin
            exp_flags[2] = 1'b1;
            flush_left   = FlushN - 1;
        end else if (v) begin
            if (op >= 4'd8) begin
                exp_flags[1] = 1'b1;
            end else begin
                exp_ctrl = SpecTbl[op[2:0]];
                if (op == 4'd2) begin
                    exp_ctrl[8] = 1'b0;
                    exp_flags   = 6'b100000;
                    wait_n      = 0;
                end
            end
        end
    endtask

    task automatic step(input string tag, input logic r, input logic [3:0] op, input logic v,
                        input logic d, input logic j);
        logic [9:0] got_c;
        logic [5:0] got_f;
        rst             = r;
        bus.opcode      = op;
        bus.instr_valid = v;
        bus.alu_done    = d;
        bus.jump_taken  = j;
        @(posedge clk);
        #1;
        model(r, op, v, d, j);
        got_c = {bus.rd_register_en, bus.wb_enable, bus.rd_mem_en, bus.wr_mem_en, bus.mux_id,
                 bus.mux_exe, bus.mux_mem, bus.jenable, bus.alu_op};
        got_f = {bus.alu_start, bus.pc_en, bus.stall, bus.flush, bus.illegal, bus.timeout};
        n_assert++;
        assert (got_c === exp_ctrl) else begin
            n_fail++;
            $error("FAIL %s ctrl: got %b expected %b", tag, got_c, exp_ctrl);
        end
        n_assert++;
        assert (got_f === exp_flags) else begin
            n_fail++;
            $error("FAIL %s flags: got %b expected %b", tag, got_f, exp_flags);
        end
    endtask

    initial begin
        rst             = 1'b1;
        bus.opcode      = '0;
        bus.instr_valid = 1'b0;
        bus.alu_done    = 1'b0;
        bus.jump_taken  = 1'b0;

        step("reset0", 1'b1, 4'd7, 1'b1, 1'b0, 1'b0);
        step("reset1", 1'b1, 4'd1, 1'b1, 1'b1, 1'b1);
        step("release", 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);

        // Every base opcode except MODEX in RUN.
        for (int i = 0; i < 8; i++) begin
            if (i != 2) step("decode", 1'b0, 4'(i), 1'b1, 1'b0, 1'b0);
        end
        step("bubble", 1'b0, 4'd7, 1'b0, 1'b0, 1'b0);

        // MODEX completing after five stall cycles.
        step("modex_issue", 1'b0, 4'd2, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) step("modex_wait", 1'b0, 4'd7, 1'b1, 1'b0, 1'b0);
        step("modex_done", 1'b0, 4'd7, 1'b1, 1'b1, 1'b0);
        step("modex_after", 1'b0, 4'd7, 1'b1, 1'b1, 1'b0);

        // MODEX that never completes.
        step("to_issue", 1'b0, 4'd2, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < Timeout + 2; i++) step("to_wait", 1'b0, 4'd4, 1'b1, 1'b0, 1'b0);

        // Taken jump, including jump_taken held high during the bubbles.
        step("jump", 1'b0, 4'd6, 1'b1, 1'b0, 1'b1);
        step("flush1", 1'b0, 4'd1, 1'b1, 1'b0, 1'b1);
        step("flush2", 1'b0, 4'd3, 1'b1, 1'b0, 1'b0);
        step("post_jump", 1'b0, 4'd3, 1'b1, 1'b0, 1'b0);

        // Jump beats a MODEX in the same cycle.
        step("jump_vs_modex", 1'b0, 4'd2, 1'b1, 1'b0, 1'b1);
        step("jvm_flush", 1'b0, 4'd0, 1'b1, 1'b1, 1'b0);
        step("jvm_after", 1'b0, 4'd0, 1'b1, 1'b1, 1'b0);

        // Undefined opcode.
        step("illegal", 1'b0, 4'd9, 1'b1, 1'b0, 1'b0);
        step("after_illegal", 1'b0, 4'd15, 1'b0, 1'b0, 1'b0);

        // Reset during the third wait cycle, then a stray alu_done.
        step("rst_issue", 1'b0, 4'd2, 1'b1, 1'b0, 1'b0);
        step("rst_wait1", 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
        step("rst_wait2", 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
        step("rst_abort", 1'b1, 4'd0, 1'b0, 1'b0, 1'b0);
        step("rst_stray_done", 1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
        step("rst_resume", 1'b0, 4'd5, 1'b1, 1'b0, 1'b0);

        // Random traffic, modelled from the same rules.
        for (int i = 0; i < 400; i++) begin
            step("random", ($urandom_range(0, 39) == 0), 4'($urandom_range(0, 15)),
                 ($urandom_range(0, 3) != 0), ($urandom_range(0, 5) == 0),
                 ($urandom_range(0, 7) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/control_unit_mc.md
CONTROL_UNIT_MC -- requirements
Module: control_unit_mc

Interface
REQ-001 Parameter ARQ, default 16, SHALL set the datapath word width; it is carried for compatibility and does not affect control logic.
REQ-002 Parameter OPCODE_W, default 3, minimum 3, SHALL set the opcode width.
REQ-003 Parameter MC_TIMEOUT, default 64, SHALL set the maximum cycles spent waiting for a multi-cycle ALU result.
REQ-004 Parameter FLUSH_CYCLES, default 2, range 1..7, SHALL set the number of bubble cycles inserted after a taken jump.
REQ-005 Ports SHALL be, with clock and reset first:
- clk  in  1  sole clock.
- rst  in  1  synchronous, active-high reset.
- opcode  in  OPCODE_W  ID-stage opcode.
- instr_valid  in  1  opcode is valid this cycle.
- alu_done  in  1  multi-cycle MODEX result ready.
- jump_taken  in  1  EX resolved JEQ-true or J.
- rd_register_en, wb_enable, rd_mem_en, wr_mem_en, mux_id, mux_exe, mux_mem, jenable  out  1 each  registered decode controls.
- alu_op  out  2  ALU select.
- alu_start  out  1  one-cycle MODEX launch pulse.
- pc_en  out  1  PC advance enable.
- stall  out  1  freeze IF/ID.
- flush  out  1  squash IF/ID.
- illegal  out  1  one-cycle pulse on undefined opcode.
- timeout  out  1  one-cycle pulse on MODEX timeout.

Function
REQ-006 Decode SHALL be registered, so that outputs reflect the opcode accepted in the previous cycle (latency of 1).
REQ-007 The opcode map SHALL be as follows, with fields ordered rd_reg/wb/rd_mem/wr_mem/mux_id/mux_exe/mux_mem/jen/alu_op:
- 0 SET: 0/1/0/0/0/1/0/0/11.
- 1 LDPX: 1/1/1/0/1/1/0/0/11.
- 2 MODEX: 1/1/0/0/1/0/0/0/10.
- 3 STPX: 1/0/0/1/0/1/1/0/11.
- 4 CMPEQ: 1/0/0/0/0/1/0/0/01.
- 5 JEQ and 6 J: 0/0/0/0/1/1/0/1/11.
- 7 ADD: 1/1/0/0/1/1/0/0/00.
REQ-008 Opcodes at or above 8 (only possible when OPCODE_W>3) SHALL produce NOP controls (all zero, alu_op=11) and pulse illegal for 1 cycle; the PC SHALL continue to advance.
REQ-009 When instr_valid=0, a NOP SHALL be issued.
REQ-010 The FSM SHALL have three states: RUN, MC_WAIT and FLUSH.
REQ-011 In RUN with a valid MODEX: issue the MODEX controls, pulse alu_start, and go to MC_WAIT.
REQ-012 In MC_WAIT: stall=1 and pc_en=0, controls are held at their MODEX values, and a cycle counter increments.
REQ-013 MC_WAIT SHALL exit to RUN with stall=0 on the cycle after alu_done=1; wb_enable SHALL be asserted for exactly that exit cycle.
REQ-014 If the counter reaches MC_TIMEOUT without alu_done: pulse timeout, force wb_enable=0, and return to RUN.
REQ-015 In RUN with jump_taken=1: go to FLUSH, and set flush=1 and NOP controls for FLUSH_CYCLES cycles.
REQ-016 In FLUSH, pc_en=1 (the target is fetched) and the down-counter returns to RUN at 0.
REQ-017 jump_taken during MC_WAIT or FLUSH SHALL be ignored; this is impossible by construction.
REQ-018 If jump_taken and a valid MODEX occur in the same RUN cycle, the jump SHALL win: the MODEX is squashed and alu_start is not pulsed.
REQ-019 alu_done outside MC_WAIT SHALL be ignored.
REQ-020 In RUN, pc_en=1 except on the issuing cycle of MODEX, where pc_en=0.
REQ-021 The MODEX counter SHALL be $clog2(MC_TIMEOUT+1) bits wide and saturate; it SHALL never wrap.

Reset
REQ-022 With rst=1 at a clock edge, the next state SHALL be RUN, all counters SHALL be 0, and every output SHALL be 0 except pc_en=0 and alu_op=11.
REQ-023 On the first cycle after reset release, pc_en=1.
REQ-024 Reset in MC_WAIT or FLUSH SHALL abort immediately, with no timeout or illegal pulse.

Structure
REQ-025 Package cu_pkg SHALL hold:
- The opcode enum (SET, LDPX, MODEX, STPX, CMPEQ, JEQ, J, ADD).
- The alu_op localparams (ADD=00, CMP=01, MOD=10, PASS=11).
- The control-bundle struct.
- The FSM state enum.
REQ-026 Sub-module cu_decode SHALL be the pure combinational opcode-to-bundle map; control_unit_mc SHALL own the FSM, the counters and the output registers.

Verification
REQ-027 Each opcode 0..7 with instr_valid=1 in RUN: the bundle per REQ-007 appears 1 cycle later, with pc_en=1.
REQ-028 MODEX with alu_done raised after 5 cycles: alu_start pulses once, stall=1 for 5 cycles, then wb_enable=1 for 1 cycle and RUN resumes.
REQ-029 MODEX with alu_done never raised and MC_TIMEOUT=8: timeout pulses after 8 wait cycles, wb_enable stays 0, and the unit returns to RUN.
REQ-030 J with jump_taken=1 and FLUSH_CYCLES=2: flush=1 for exactly 2 cycles with NOP controls, then normal decode resumes.
REQ-031 With OPCODE_W=4 and opcode 9: illegal pulses once, controls are NOP, and pc_en=1.
REQ-032 rst asserted in the 3rd MC_WAIT cycle: on the next cycle the FSM is in RUN, all outputs are at reset values, and a later alu_done is ignored.
